// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: register IDs, stage controls, memory
// handshake, and the stall/flush/forward/status outputs.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]       RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW;
    logic             PCSrcE;
    logic             MemReqM, MemReadyM;

    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             MemBusy, MemErr;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    // pipeline side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemBusy, MemErr, StallCycles, FlushCount
    );

    // controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemBusy, MemErr, StallCycles, FlushCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage OTTER: forwarding, load-use and
// memory-wait stalls, branch flushes, memory timeout FSM and perf counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   RUN      | normal flow, no outstanding data-memory access
//   MEM_WAIT | M-stage access pending, whole pipe frozen, counting wait
//   ERROR    | access timed out, pipe frozen until RST
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32,
    parameter int WAIT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              mem_pending, mem_stall, lw_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        if (reg_write_m && rd_m == rs && rs != 5'd0)      return 2'b10;
        else if (reg_write_w && rd_w == rs && rs != 5'd0) return 2'b01;
        else                                              return 2'b00;
    endfunction

    assign mem_pending = bus.MemReqM && !bus.MemReadyM;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (mem_pending) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_pending) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (TIMEOUT != 0 && wait_q == TIMEOUT_V) begin
                    state_d = ERROR;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERROR:   state_d = ERROR;
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        mem_stall = (state_q == ERROR) || mem_pending;
        lw_stall  = bus.ResultSrcE == 2'b01 && bus.RdE != 5'd0 &&
                    (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D) && !bus.PCSrcE;

        bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
        bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
        bus.StallF    = 1'b0;
        bus.StallD    = 1'b0;
        bus.StallE    = 1'b0;
        bus.StallM    = 1'b0;
        bus.FlushD    = 1'b0;
        bus.FlushE    = 1'b0;
        bus.FlushW    = 1'b0;

        if (RST) begin
            bus.ForwardAE = 2'b00;
            bus.ForwardBE = 2'b00;
            bus.FlushD    = 1'b1;
            bus.FlushE    = 1'b1;
            bus.FlushW    = 1'b1;
        end else if (mem_stall) begin
            // Branch and load-use are deferred; W takes a bubble so the
            // frozen M instruction is not written back twice.
            bus.StallF = 1'b1;
            bus.StallD = 1'b1;
            bus.StallE = 1'b1;
            bus.StallM = 1'b1;
            bus.FlushW = 1'b1;
        end else begin
            bus.StallF = lw_stall;
            bus.StallD = lw_stall;
            bus.FlushD = bus.PCSrcE;
            bus.FlushE = bus.PCSrcE || lw_stall;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.StallF && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (bus.PCSrcE && !mem_stall && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.MemBusy     = (state_q == MEM_WAIT);
    assign bus.MemErr      = (state_q == ERROR);
    assign bus.StallCycles = stall_cnt_q;
    assign bus.FlushCount  = flush_cnt_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipelined OTTER.
- Drives stall/flush enables for the F/D/E/M/W pipeline registers and the E-stage forwarding selects.
- Freezes the pipeline while a data-memory access in M is outstanding, with a timeout-to-error FSM.
- Keeps saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 255: max consecutive MEM_WAIT cycles before ERROR; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.
- WAIT_W, 8: width of the wait counter; must hold TIMEOUT.

Ports:
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  5 each  source regs in D
- Rs1E, Rs2E  in  5 each  source regs in E
- RdE, RdM, RdW  in  5 each  destination regs in E/M/W
- ResultSrcE  in  2  result select in E; 2'b01 = load
- RegWriteM, RegWriteW  in  1 each  regfile write enables in M/W
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM  in  1  M-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2 each  00 regfile, 01 W result, 10 M ALU result
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the stage register
- MemBusy  out  1  FSM in MEM_WAIT
- MemErr  out  1  FSM in ERROR (sticky until RST)
- StallCycles  out  CNT_W  cycles with StallF=1
- FlushCount  out  CNT_W  accepted branch redirects

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. All state and counters are registered; stall, flush and forward outputs are combinational from inputs plus state.
- Reset: while RST=1, FlushD=FlushE=FlushW=1, all Stall*=0 and Forward*=00. On the next edge: state=RUN, wait counter=0, StallCycles=0, FlushCount=0, MemErr=0, MemBusy=0.
- Forwarding (A shown, B identical with Rs2E):
  - 10 if RegWriteM and RdM==Rs1E and Rs1E!=0.
  - else 01 if RegWriteW and RdW==Rs1E and Rs1E!=0.
  - else 00.
  - M has priority over W. Forwarding is computed in every state.
- memStall = (MemReqM and not MemReadyM) in RUN/MEM_WAIT; memStall = 1 in ERROR.
- If memStall:
  - StallF=StallD=StallE=StallM=1, FlushW=1 (W gets a bubble, so no duplicate writeback), FlushD=FlushE=0.
  - PCSrcE and load-use are ignored that cycle; they are re-evaluated when released.
- Else (normal operation):
  - lwStall = ResultSrcE==01 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D) and not PCSrcE.
  - StallF=StallD=lwStall, FlushD=PCSrcE, FlushE=PCSrcE or lwStall, StallE=StallM=FlushW=0.
  - PCSrcE wins over lwStall.
- Zero-latency release: in the cycle MemReadyM=1, memStall=0 and the pipeline advances.
- FSM transitions:
  - RUN -> MEM_WAIT when MemReqM and not MemReadyM; wait counter <= 1.
  - MEM_WAIT -> RUN when MemReadyM=1 or MemReqM=0; wait counter <= 0.
  - MEM_WAIT stays in MEM_WAIT while MemReqM and not MemReadyM; wait counter increments.
  - MEM_WAIT -> ERROR when TIMEOUT!=0 and wait counter==TIMEOUT and still not ready.
  - ERROR is terminal until RST; MemReadyM is ignored there.
- MemBusy = (state==MEM_WAIT); MemErr = (state==ERROR).
- StallCycles increments on each cycle with StallF=1 and RST=0; it saturates at all-ones.
- FlushCount increments when PCSrcE=1 and memStall=0 and RST=0; it saturates at all-ones.
- Boundaries:
  - x0 never forwards and never causes lwStall.
  - RST mid-MEM_WAIT or in ERROR returns to RUN and clears the counters on the next edge.
  - Simultaneous MemReqM with PCSrcE: the memory stall wins and the branch is applied once, on the release cycle.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- Load-use: ResultSrcE=01, RdE=3, Rs2D=3, PCSrcE=0 -> StallF=StallD=FlushE=1, FlushD=0, StallCycles +1. Same inputs with PCSrcE=1 -> StallF=0, FlushD=FlushE=1, FlushCount +1.
- Mem wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF..StallM=1 and FlushW=1 for 3 cycles, MemBusy=1 for cycles 2-4, all released on cycle 4, StallCycles=3.
- Branch during wait: PCSrcE=1 held across a 2-cycle wait -> FlushD=0 while stalled, FlushD=FlushE=1 on the release cycle, FlushCount increments exactly once.
- Timeout: TIMEOUT=4, MemReqM=1, MemReadyM never asserted -> MemErr=1 after cycle 5. All stalls held even after MemReadyM=1. RST pulse -> RUN, MemErr=0, counters 0.
- Reset mid-op: assert RST during MEM_WAIT with StallCycles=7 -> FlushD/E/W=1 and stalls 0 during RST; StallCycles=0 and MemBusy=0 after the edge.
